// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW interlock for the scalar/vector pipeline.
// Per-register 2-bit pending-writer counters for both banks drive
// combinational stall/bubble outputs; a small FSM sequences the one-cycle
// IF/ID flush after a taken branch issues. Saturating stall/flush counters.
module hazard_scoreboard #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [4:0]       id_vn,
  input  logic [4:0]       id_vm,
  input  logic             id_use_vn,
  input  logic             id_use_vm,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_vd,
  input  logic             id_wr_s,
  input  logic             id_wr_v,
  input  logic             id_br_taken,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [4:0]       wb_vd,
  input  logic             wb_wr_s,
  input  logic             wb_wr_v,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             issue,
  output logic [31:0]      busy_s,
  output logic [31:0]      busy_v,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             hazard;
  logic             flush_active;
  logic             inc_s_en, inc_v_en, dec_s_en, dec_v_en;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_cycles_q, flush_cycles_d;

  // Next value of one pending-writer counter: simultaneous inc/dec cancel,
  // increment saturates at 3, decrement of an empty counter stays at 0.
  function automatic logic [1:0] next_cnt(input logic [1:0] cnt,
                                          input logic       inc,
                                          input logic       dec);
    logic [1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
    end else if (dec && !inc) begin
      res = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
    end
    return res;
  endfunction

  assign inc_s_en = issue & id_wr_s;
  assign inc_v_en = issue & id_wr_v;
  assign dec_s_en = wb_we & wb_wr_s;
  assign dec_v_en = wb_we & wb_wr_v;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      logic [1:0] cnt_s_q, cnt_s_d;
      logic [1:0] cnt_v_q, cnt_v_d;

      // Per-register counter next-state for both banks.
      always_comb begin
        cnt_s_d = next_cnt(cnt_s_q,
                           inc_s_en && (id_rd == 5'(gi)),
                           dec_s_en && (wb_rd == 5'(gi)));
        cnt_v_d = next_cnt(cnt_v_q,
                           inc_v_en && (id_vd == 5'(gi)),
                           dec_v_en && (wb_vd == 5'(gi)));
      end

      // Counter registers; reset discards every in-flight writer.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_s_q <= 2'd0;
          cnt_v_q <= 2'd0;
        end else begin
          cnt_s_q <= cnt_s_d;
          cnt_v_q <= cnt_v_d;
        end
      end

      assign busy_s[gi] = (cnt_s_q != 2'd0);
      assign busy_v[gi] = (cnt_v_q != 2'd0);
    end
  endgenerate

  // Source-versus-pending-write check; WB writes are not bypassed, so a
  // register stays busy until its counter actually drops.
  always_comb begin
    hazard = id_valid & ((id_use_rn & busy_s[id_rn]) |
                         (id_use_rm & busy_s[id_rm]) |
                         (id_use_vn & busy_v[id_vn]) |
                         (id_use_vm & busy_v[id_vm]));
  end

  // Interlock FSM: stall outputs follow the hazard combinationally; the
  // flush cycle discards the wrong-path instruction in ID and overrides stall.
  always_comb begin
    state_d      = RUN;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    bubble_ex    = 1'b0;
    flush_id     = 1'b0;
    flush_active = (state_q == FLUSH);
    issue        = id_valid & ~hazard & ~flush_active;

    case (state_q)
      FLUSH: begin
        flush_id = 1'b1;
      end
      default: begin
        stall_if  = hazard;
        stall_id  = hazard;
        bubble_ex = hazard;
      end
    endcase

    if (issue && id_br_taken) begin
      state_d = FLUSH;
    end else if (hazard && !flush_active) begin
      state_d = STALL;
    end else begin
      state_d = RUN;
    end
  end

  // Saturating performance counter next values.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (stall_id && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (flush_id && !(&flush_cycles_q)) begin
      flush_cycles_d = flush_cycles_q + 1'b1;
    end
  end

  // FSM state and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard. The reference model is a three-stage
// EX/MEM/WB pipeline of issued writers: a register is busy when any stage
// holds a writer for it, and WB writebacks are replayed from the model's WB stage.
module tb_hazard_scoreboard;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rn, id_rm, id_vn, id_vm, id_rd, id_vd;
  logic             id_use_rn, id_use_rm, id_use_vn, id_use_vm;
  logic             id_wr_s, id_wr_v, id_br_taken;
  logic             wb_we;
  logic [4:0]       wb_rd, wb_vd;
  logic             wb_wr_s, wb_wr_v;
  logic             stall_if, stall_id, bubble_ex, flush_id, issue;
  logic [31:0]      busy_s, busy_v;
  logic [CNT_W-1:0] stall_cycles, flush_cycles;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_vn(id_vn), .id_vm(id_vm), .id_use_vn(id_use_vn), .id_use_vm(id_use_vm),
    .id_rd(id_rd), .id_vd(id_vd), .id_wr_s(id_wr_s), .id_wr_v(id_wr_v),
    .id_br_taken(id_br_taken),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_vd(wb_vd), .wb_wr_s(wb_wr_s), .wb_wr_v(wb_wr_v),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .issue(issue),
    .busy_s(busy_s), .busy_v(busy_v),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] rn, rm, vn, vm, rd, vd;
    logic       use_rn, use_rm, use_vn, use_vm;
    logic       wr_s, wr_v, br;
  } instr_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd, vd;
    logic       wr_s, wr_v;
  } stage_t;

  // Reference model state
  stage_t      ex_m, mem_m, wb_m;
  bit          fl_m;
  int unsigned stall_m, flush_m;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy(input bit vec);
    logic [31:0] b;
    stage_t st[3];
    b = '0;
    st[0] = ex_m; st[1] = mem_m; st[2] = wb_m;
    for (int k = 0; k < 3; k++) begin
      if (st[k].valid) begin
        if (!vec && st[k].wr_s) b[st[k].rd] = 1'b1;
        if (vec && st[k].wr_v)  b[st[k].vd] = 1'b1;
      end
    end
    return b;
  endfunction

  function automatic instr_t idle_i();
    instr_t t;
    t = '0;
    return t;
  endfunction

  function automatic instr_t w_s(input logic [4:0] r);
    instr_t t;
    t = '0; t.valid = 1'b1; t.rd = r; t.wr_s = 1'b1; t.vd = 5'd31 - r;
    return t;
  endfunction

  function automatic instr_t w_v(input logic [4:0] r);
    instr_t t;
    t = '0; t.valid = 1'b1; t.vd = r; t.wr_v = 1'b1; t.rd = 5'd31 - r;
    return t;
  endfunction

  function automatic instr_t r_s(input logic [4:0] r, input logic br);
    instr_t t;
    t = '0; t.valid = 1'b1; t.rn = r; t.use_rn = 1'b1; t.rm = 5'd30; t.br = br;
    return t;
  endfunction

  function automatic instr_t r_v(input logic [4:0] r);
    instr_t t;
    t = '0; t.valid = 1'b1; t.vm = r; t.use_vm = 1'b1; t.vn = 5'd29;
    return t;
  endfunction

  function automatic instr_t rand_i();
    instr_t t;
    t.valid  = ($urandom_range(0, 3) != 0);
    t.rn     = 5'($urandom_range(0, 7));
    t.rm     = 5'($urandom_range(0, 7));
    t.vn     = 5'($urandom_range(0, 7));
    t.vm     = 5'($urandom_range(0, 7));
    t.rd     = 5'($urandom_range(0, 7));
    t.vd     = 5'($urandom_range(0, 7));
    t.use_rn = 1'($urandom_range(0, 1));
    t.use_rm = 1'($urandom_range(0, 1));
    t.use_vn = 1'($urandom_range(0, 1));
    t.use_vm = 1'($urandom_range(0, 1));
    t.wr_s   = 1'($urandom_range(0, 1));
    t.wr_v   = 1'($urandom_range(0, 1));
    t.br     = ($urandom_range(0, 7) == 0);
    return t;
  endfunction

  task automatic drive_id(input instr_t ins);
    id_valid = ins.valid;
    id_rn = ins.rn; id_rm = ins.rm; id_vn = ins.vn; id_vm = ins.vm;
    id_use_rn = ins.use_rn; id_use_rm = ins.use_rm;
    id_use_vn = ins.use_vn; id_use_vm = ins.use_vm;
    id_rd = ins.rd; id_vd = ins.vd;
    id_wr_s = ins.wr_s; id_wr_v = ins.wr_v; id_br_taken = ins.br;
  endtask

  task automatic drive_wb();
    wb_we   = wb_m.valid;
    wb_rd   = wb_m.rd;
    wb_vd   = wb_m.vd;
    wb_wr_s = wb_m.wr_s;
    wb_wr_v = wb_m.wr_v;
  endtask

  task automatic clear_model();
    ex_m = '0; mem_m = '0; wb_m = '0;
    fl_m = 1'b0; stall_m = 0; flush_m = 0;
  endtask

  // One clock of operation: drive, check against the model mid-cycle, advance.
  task automatic cycle(input instr_t ins, output bit iss_obs, output bit stall_obs,
                       output bit iss_exp);
    logic [31:0] bs, bv;
    bit hz, st_e, is_e;
    rst = 1'b0;
    drive_id(ins);
    drive_wb();
    bs = model_busy(1'b0);
    bv = model_busy(1'b1);
    hz = ins.valid && ((ins.use_rn && bs[ins.rn]) || (ins.use_rm && bs[ins.rm]) ||
                       (ins.use_vn && bv[ins.vn]) || (ins.use_vm && bv[ins.vm]));
    st_e = hz && !fl_m;
    is_e = ins.valid && !hz && !fl_m;
    @(negedge clk);
    check_eq("stall_id", stall_id, st_e);
    check_eq("stall_if", stall_if, st_e);
    check_eq("bubble_ex", bubble_ex, st_e);
    check_eq("flush_id", flush_id, fl_m);
    check_eq("issue", issue, is_e);
    check_eq("busy_s", busy_s, bs);
    check_eq("busy_v", busy_v, bv);
    check_eq("stall_cycles", stall_cycles, stall_m);
    check_eq("flush_cycles", flush_cycles, flush_m);
    iss_obs   = issue;
    stall_obs = stall_id;
    iss_exp   = is_e;
    @(posedge clk);
    wb_m  = mem_m;
    mem_m = ex_m;
    ex_m  = '0;
    if (is_e && (ins.wr_s || ins.wr_v)) begin
      ex_m.valid = 1'b1; ex_m.rd = ins.rd; ex_m.vd = ins.vd;
      ex_m.wr_s = ins.wr_s; ex_m.wr_v = ins.wr_v;
    end
    if (st_e) stall_m++;
    if (fl_m) flush_m++;
    fl_m = is_e && ins.br;
    #1;
  endtask

  // Reset for n edges with random ID inputs; WB carries the model's pending writer if any.
  task automatic do_reset(input int n);
    rst = 1'b1;
    drive_id(rand_i());
    if (wb_m.valid) begin
      drive_wb();
    end else begin
      wb_we = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 31));
      wb_vd = 5'($urandom_range(0, 31)); wb_wr_s = 1'($urandom_range(0, 1));
      wb_wr_v = 1'($urandom_range(0, 1));
    end
    repeat (n) @(posedge clk);
    clear_model();
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a, b, c;
    for (int k = 0; k < n; k++) cycle(idle_i(), a, b, c);
  endtask

  // Hold one instruction in ID until it issues; returns number of stall cycles.
  task automatic run_until_issue(input instr_t ins, input string tag, output int stalls);
    bit io, so, ie;
    bit done;
    stalls = 0;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      cycle(ins, io, so, ie);
      if (so) stalls++;
      if (io) done = 1'b1;
    end
    if (!done) check_eq({tag, "_issue_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    bit io, so, ie;
    int n;
    logic [CNT_W-1:0] fbase, sbase;
    instr_t cur;

    clear_model();
    rst = 1'b1;
    drive_id(idle_i());
    drive_wb();

    // Reset with random inputs, then first cycle checks idle outputs and issue = id_valid
    do_reset(2);
    cycle(rand_i(), io, so, ie);
    idle(4);

    // Scalar RAW at distance 1: three stall cycles
    sbase = stall_cycles;
    cycle(w_s(5'd5), io, so, ie);
    run_until_issue(r_s(5'd5, 1'b0), "raw_s", n);
    check_eq("raw_s_stalls", n, 3);
    check_eq("raw_s_stall_delta", stall_cycles - sbase, 3);
    idle(4);

    // Vector write v7; scalar x7 reader unaffected, v7 reader stalls at distance 2
    cycle(w_v(5'd7), io, so, ie);
    check_eq("vec_busy_v7", busy_v[7], 1'b1);
    check_eq("vec_busy_s7", busy_s[7], 1'b0);
    run_until_issue(r_s(5'd7, 1'b0), "vec_rs7", n);
    check_eq("vec_rs7_stalls", n, 0);
    check_eq("vec_busy_v7_b", busy_v[7], 1'b1);
    run_until_issue(r_v(5'd7), "vec_rv7", n);
    check_eq("vec_rv7_stalls", n, 2);
    idle(4);

    // Two writers to x3; consumer issues one cycle after the second WB
    cycle(w_s(5'd3), io, so, ie);
    cycle(w_s(5'd3), io, so, ie);
    run_until_issue(r_s(5'd3, 1'b0), "dbl", n);
    check_eq("dbl_stalls", n, 3);
    idle(4);

    // Taken branch without hazard: one flush pulse
    fbase = flush_cycles;
    run_until_issue(r_s(5'd1, 1'b1), "br", n);
    cycle(idle_i(), io, so, ie);
    cycle(idle_i(), io, so, ie);
    check_eq("br_flush_delta", flush_cycles - fbase, 1);

    // Taken branch behind a hazard: no flush during stall, one pulse after issue
    fbase = flush_cycles;
    cycle(w_s(5'd9), io, so, ie);
    run_until_issue(r_s(5'd9, 1'b1), "brhz", n);
    check_eq("brhz_stalls", n, 3);
    check_eq("brhz_no_early_flush", flush_cycles - fbase, 0);
    cycle(idle_i(), io, so, ie);
    cycle(idle_i(), io, so, ie);
    check_eq("brhz_flush_delta", flush_cycles - fbase, 1);
    idle(4);

    // Reset while stalled on x5, with the x5 writeback presented during reset
    cycle(w_s(5'd5), io, so, ie);
    cycle(r_s(5'd5, 1'b0), io, so, ie);
    check_eq("rst_mid_stalling", so, 1'b1);
    cycle(r_s(5'd5, 1'b0), io, so, ie);
    do_reset(1);
    check_eq("rst_mid_busy_s5", busy_s[5], 1'b0);
    cycle(r_s(5'd5, 1'b0), io, so, ie);
    check_eq("rst_mid_issue", io, 1'b1);
    run_until_issue(w_s(5'd5), "rst_w5", n);
    run_until_issue(r_s(5'd5, 1'b0), "rst_r5", n);
    check_eq("rst_after_stalls", n, 3);
    idle(4);

    // Randomized traffic against the pipeline model
    cur = rand_i();
    for (int k = 0; k < 600; k++) begin
      if (fl_m) begin
        cycle(idle_i(), io, so, ie);
      end else begin
        cycle(cur, io, so, ie);
        if (ie || !cur.valid) cur = rand_i();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline interlock controller for the five-stage scalar/vector processor. It tracks in-flight writes to both the 32-entry scalar bank and the 32-entry 48-bit vector bank with per-register pending counters. It stalls the fetch and decode stages while a decode-stage instruction reads a register with an outstanding write, and inserts a bubble into ID/EX during the stall. It also flushes IF/ID on a taken branch and keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 32: width of performance counters
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rn, id_rm  in  5 each  scalar source indices
- id_use_rn, id_use_rm  in  1 each  scalar source actually read
- id_vn, id_vm  in  5 each  vector source indices
- id_use_vn, id_use_vm  in  1 each  vector source actually read
- id_rd, id_vd  in  5 each  scalar / vector destination
- id_wr_s, id_wr_v  in  1 each  instruction writes scalar / vector bank
- id_br_taken  in  1  decode resolved a taken branch (pc_src)
- wb_we  in  1  reg_write at writeback stage
- wb_rd, wb_vd  in  5 each  writeback destinations
- wb_wr_s, wb_wr_v  in  1 each  writeback targets scalar / vector bank
- stall_if  out  1  hold PC and instruction memory address
- stall_id  out  1  hold IF/ID register
- bubble_ex  out  1  load NOP (all control zero) into ID/EX
- flush_id  out  1  clear IF/ID next edge
- issue  out  1  instruction leaves ID this cycle
- busy_s, busy_v  out  32 each  bit i = register i has pending write
- stall_cycles, flush_cycles  out  CNT_W each  saturating counters

## Operation
- Scoreboard: 2-bit counter per register per bank (64 total); max 3 writers in flight (EX, MEM, WB); busy_x[i] = (cnt != 0). Register 0 not special.
- hazard = id_valid & any used source with busy bit set (rn/rm vs busy_s, vn/vm vs busy_v).
- issue = id_valid & ~hazard.
- Increment on issue & id_wr_s for id_rd; increment on issue & id_wr_v for id_vd. id_rd and id_vd increment independently.
- Decrement on wb_we & wb_wr_s for wb_rd; same for the vector bank.
- Same register incremented and decremented in one cycle: counter unchanged.
- Decrement of a zero counter: held at 0 (illegal, not asserted).
- Increment at 3: held at 3; cannot occur in a 5-stage pipe.
- FSM states:
  - RUN: no hazard; outputs idle.
  - STALL: hazard. stall_if = stall_id = bubble_ex = 1. Returns to RUN in the cycle the hazard clears (combinational on counters).
  - FLUSH: entered from issue & id_br_taken. flush_id = 1 for exactly one cycle; stall_if = 0 so the branch target is fetched. Returns to RUN.
- id_br_taken is ignored while hazard = 1; the branch is honored only when it issues.
- WB write is not bypassed: a source whose only pending writer is in WB still stalls that cycle.
- stall_cycles increments each cycle stall_id = 1; flush_cycles increments each cycle flush_id = 1; both saturate at all-ones.
- flush_id and stall_id are never both 1.

## Timing
- Reset (rst = 1 at a clk edge): all counters 0, FSM = RUN, stall_cycles = flush_cycles = 0.
- Outputs after reset: stall_if = stall_id = bubble_ex = flush_id = 0, busy_s = busy_v = 0, issue = id_valid.
- rst mid-operation overrides all increments and decrements in that cycle.
- Stall outputs are combinational from the counters and the ID fields, valid in the same cycle. Counters and FSM update on the clk rising edge.
- Back-to-back RAW, producer issues in cycle t:
  - busy set in t+1.
  - Consumer in ID stalls t+1, t+2, t+3 (3 cycles).
  - WB decrements at the end of t+3; consumer issues at t+4.
- Dependency at distance 2: 2 stall cycles. Distance 3: 1. Distance 4 or more: 0.
- Taken branch issuing at t: flush_id = 1 during t+1; the instruction fetched in t is discarded.

## Test plan
- Reset: drive rst 2 cycles with random inputs -> all outputs 0, busy_s = busy_v = 0, counters 0.
- Scalar RAW: issue writer x5, then reader of x5 next cycle, wb_we for x5 at t+3 -> stall_id high exactly 3 cycles, issue at t+4, stall_cycles = 3.
- Vector RAW plus same-index scalar: write v7, then read x7 only -> no stall. Then read v7 -> stall; busy_v[7] = 1 and busy_s[7] = 0 throughout.
- Double writer: two back-to-back writes to x3 -> counter reaches 2. After first WB, busy_s[3] is still 1. After second WB, busy_s[3] = 0. A consumer of x3 issues one cycle after the second WB.
- Branch: taken branch with no hazard -> flush_id pulses 1 cycle, flush_cycles = 1. Taken branch while hazard -> no flush until issue, then a single flush pulse.
- Reset mid-stall: with busy_s[5] = 1 and stall active, pulse rst -> next cycle busy_s = 0, stall_id = 0, and the pending WB decrement has no effect.
